// File: rtl/pu_riscv_pmachk_arb.sv
// pu_riscv_pmachk_arb
//   Shares one combinational PMA checker between the instruction-fetch and
//   data-memory requesters. A request is accepted in IDLE (round-robin on a
//   tie), its attributes are latched and presented to the checker for exactly
//   one CHECK cycle, and the captured result is held in RESP until the
//   consumer takes it. flush_i abandons any in-flight check.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  abort in-flight check / block acceptance
//   if_req_i/if_ack_o        fetch request / accept, with if_adr_i, if_size_i
//   dm_req_i/dm_ack_o        data request / accept, with dm_adr_i, dm_size_i,
//                            dm_lock_i, dm_we_i, dm_misaligned_i
//   rsp_valid_o/rsp_ready_i  response handshake; rsp_port_o names the owner
//   rsp_*_o                  registered checker results
//   chk_*_o                  request to the shared checker
//   chk_*_i                  combinational checker results
module pu_riscv_pmachk_arb #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,

  input  logic            if_req_i,
  output logic            if_ack_o,
  input  logic [PLEN-1:0] if_adr_i,
  input  logic [2:0]      if_size_i,

  input  logic            dm_req_i,
  output logic            dm_ack_o,
  input  logic [PLEN-1:0] dm_adr_i,
  input  logic [2:0]      dm_size_i,
  input  logic            dm_lock_i,
  input  logic            dm_we_i,
  input  logic            dm_misaligned_i,

  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_port_o,
  output logic [13:0]     rsp_pma_o,
  output logic            rsp_exception_o,
  output logic            rsp_misaligned_o,
  output logic            rsp_cache_o,
  output logic            rsp_ext_o,
  output logic            rsp_tcm_o,

  output logic            chk_req_o,
  output logic            chk_instruction_o,
  output logic            chk_lock_o,
  output logic            chk_we_o,
  output logic            chk_misaligned_o,
  output logic [PLEN-1:0] chk_adr_o,
  output logic [2:0]      chk_size_o,

  input  logic [13:0]     chk_pma_i,
  input  logic            chk_exception_i,
  input  logic            chk_misaligned_i,
  input  logic            chk_cache_i,
  input  logic            chk_ext_i,
  input  logic            chk_tcm_i
);

  // XLEN carries no logic here; reject nonsensical values at elaboration.
  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("pu_riscv_pmachk_arb: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;  // 0 = fetch, 1 = data
  logic            port_q, port_d;
  logic [PLEN-1:0] adr_q, adr_d;
  logic [2:0]      size_q, size_d;
  logic            lock_q, lock_d;
  logic            we_q, we_d;
  logic            mis_q, mis_d;
  logic            instr_q, instr_d;

  logic [13:0]     rsp_pma_q, rsp_pma_d;
  logic            rsp_exc_q, rsp_exc_d;
  logic            rsp_mis_q, rsp_mis_d;
  logic            rsp_cache_q, rsp_cache_d;
  logic            rsp_ext_q, rsp_ext_d;
  logic            rsp_tcm_q, rsp_tcm_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    adr_d        = adr_q;
    size_d       = size_q;
    lock_d       = lock_q;
    we_d         = we_q;
    mis_d        = mis_q;
    instr_d      = instr_q;
    rsp_pma_d    = rsp_pma_q;
    rsp_exc_d    = rsp_exc_q;
    rsp_mis_d    = rsp_mis_q;
    rsp_cache_d  = rsp_cache_q;
    rsp_ext_d    = rsp_ext_q;
    rsp_tcm_d    = rsp_tcm_q;
    if_ack_o     = 1'b0;
    dm_ack_o     = 1'b0;

    case (state_q)
      IDLE: begin
        // The acks are combinational, so they are qualified with rst_ni to
        // keep every output low while reset is held.
        if (rst_ni && !flush_i) begin
          // Fetch wins when alone, or on a tie when data was granted last.
          if (if_req_i && (!dm_req_i || last_grant_q)) begin
            if_ack_o     = 1'b1;
            state_d      = CHECK;
            last_grant_d = 1'b0;
            port_d       = 1'b0;
            adr_d        = if_adr_i;
            size_d       = if_size_i;
            lock_d       = 1'b0;
            we_d         = 1'b0;
            mis_d        = 1'b0;
            instr_d      = 1'b1;
          end else if (dm_req_i) begin
            dm_ack_o     = 1'b1;
            state_d      = CHECK;
            last_grant_d = 1'b1;
            port_d       = 1'b1;
            adr_d        = dm_adr_i;
            size_d       = dm_size_i;
            lock_d       = dm_lock_i;
            we_d         = dm_we_i;
            mis_d        = dm_misaligned_i;
            instr_d      = 1'b0;
          end
        end
      end
      CHECK: begin
        // A flushed check is dropped without touching the result registers.
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          state_d     = RESP;
          rsp_pma_d   = chk_pma_i;
          rsp_exc_d   = chk_exception_i;
          rsp_mis_d   = chk_misaligned_i;
          rsp_cache_d = chk_cache_i;
          rsp_ext_d   = chk_ext_i;
          rsp_tcm_d   = chk_tcm_i;
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      adr_q        <= '0;
      size_q       <= '0;
      lock_q       <= 1'b0;
      we_q         <= 1'b0;
      mis_q        <= 1'b0;
      instr_q      <= 1'b0;
      rsp_pma_q    <= '0;
      rsp_exc_q    <= 1'b0;
      rsp_mis_q    <= 1'b0;
      rsp_cache_q  <= 1'b0;
      rsp_ext_q    <= 1'b0;
      rsp_tcm_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      adr_q        <= adr_d;
      size_q       <= size_d;
      lock_q       <= lock_d;
      we_q         <= we_d;
      mis_q        <= mis_d;
      instr_q      <= instr_d;
      rsp_pma_q    <= rsp_pma_d;
      rsp_exc_q    <= rsp_exc_d;
      rsp_mis_q    <= rsp_mis_d;
      rsp_cache_q  <= rsp_cache_d;
      rsp_ext_q    <= rsp_ext_d;
      rsp_tcm_q    <= rsp_tcm_d;
    end
  end

  // Checker request fields stay at their latched values outside CHECK.
  assign chk_req_o         = (state_q == CHECK);
  assign chk_instruction_o = instr_q;
  assign chk_lock_o        = lock_q;
  assign chk_we_o          = we_q;
  assign chk_misaligned_o  = mis_q;
  assign chk_adr_o         = adr_q;
  assign chk_size_o        = size_q;

  assign rsp_valid_o       = (state_q == RESP);
  assign rsp_port_o        = port_q;
  assign rsp_pma_o         = rsp_pma_q;
  assign rsp_exception_o   = rsp_exc_q;
  assign rsp_misaligned_o  = rsp_mis_q;
  assign rsp_cache_o       = rsp_cache_q;
  assign rsp_ext_o         = rsp_ext_q;
  assign rsp_tcm_o         = rsp_tcm_q;

endmodule

// File: doc/pu_riscv_pmachk_arb.md
PU_RISCV_PMACHK_ARB -- requirements
Module: pu_riscv_pmachk_arb

Interface
REQ-001 Parameter XLEN, default 64: architectural register width, kept for codebase consistency.
REQ-002 Parameter PLEN, default 64: physical address width.
REQ-003 clk_i  in  1: single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1: reset, asynchronous, active-low.
REQ-005 flush_i  in  1: abort any in-flight check.
REQ-006 if_req_i / if_ack_o  in/out  1: instruction-fetch requester valid / accept.
REQ-007 if_adr_i  in  PLEN; if_size_i  in  3: fetch physical address and transfer size.
REQ-008 dm_req_i / dm_ack_o  in/out  1: data-memory requester valid / accept.
REQ-009 dm_adr_i  in  PLEN; dm_size_i  in  3; dm_lock_i, dm_we_i, dm_misaligned_i  in  1 each: data access attributes.
REQ-010 rsp_valid_o  out  1; rsp_ready_i  in  1: response handshake, shared by both requesters.
REQ-011 rsp_port_o  out  1: owner of the response (0 = fetch, 1 = data).
REQ-012 rsp_pma_o  out  14; rsp_exception_o, rsp_misaligned_o, rsp_cache_o, rsp_ext_o, rsp_tcm_o  out  1 each: registered check results.
REQ-013 chk_req_o, chk_instruction_o, chk_lock_o, chk_we_o, chk_misaligned_o  out  1; chk_adr_o  out  PLEN; chk_size_o  out  3: drive the shared PMA checker.
REQ-014 chk_pma_i  in  14; chk_exception_i, chk_misaligned_i, chk_cache_i, chk_ext_i, chk_tcm_i  in  1 each: combinational checker results.

Function
REQ-015 FSM states: IDLE, CHECK, RESP.
REQ-016 In IDLE, the arbiter asserts if_ack_o / dm_ack_o combinationally for at most one requester; all acks are 0 in CHECK and RESP.
REQ-017 Single request pending: that requester is granted.
REQ-018 Both requests pending: the port not granted last (last_grant register) is granted (round-robin).
REQ-019 On acceptance (req & ack), the block latches the port, address, size and attributes, updates last_grant, and moves to CHECK.
REQ-020 For a fetch acceptance, the latched lock, we and misaligned values are 0 and instruction is 1.
REQ-021 In CHECK, chk_req_o = 1 and the chk_* outputs are driven from the latched registers.
REQ-022 At the end of the CHECK cycle, all chk_*_i results are captured into the rsp_* registers, the FSM moves to RESP, and CHECK lasts exactly 1 cycle.
REQ-023 Outside CHECK, chk_req_o = 0 and the other chk_* outputs keep their latched values.
REQ-024 In RESP, rsp_valid_o = 1 and the rsp_* outputs are held stable until rsp_ready_i = 1.
REQ-025 RESP with rsp_ready_i = 1 returns to IDLE; no acceptance occurs in that cycle.
REQ-026 Latency: acceptance at cycle N gives rsp_valid_o at cycle N+2.
REQ-027 Minimum repeat interval between acceptances is 3 cycles.
REQ-028 flush_i = 1 in CHECK or RESP forces IDLE next cycle, drops the response, and deasserts rsp_valid_o next cycle.
REQ-029 flush_i = 1 in IDLE blocks acceptance (both acks 0).
REQ-030 flush_i takes priority over rsp_ready_i.
REQ-031 last_grant is unchanged by flush.
REQ-032 rsp_valid_o never asserts without a prior acceptance.
REQ-033 Requester address/size changes after acceptance do not affect the in-flight check.

Reset
REQ-034 rst_ni low forces IDLE asynchronously, from any state including mid-CHECK or mid-RESP.
REQ-035 During reset, all outputs are 0, including every rsp_* output and every chk_* output.
REQ-036 last_grant resets to 1 (data), so the first tie is granted to fetch.

Verification
REQ-037 Single fetch: if_req_i = 1, if_adr_i = 0x8000_0000, size = WORD; checker returns exception = 0, cache = 1 -> if_ack_o = 1 at N; chk_req_o = 1, chk_instruction_o = 1 at N+1; rsp_valid_o = 1, rsp_port_o = 0, rsp_cache_o = 1 at N+2.
REQ-038 Tie after reset: both requesting -> fetch granted first; with both still requesting, next grant is data, then fetch (alternation).
REQ-039 Backpressure: rsp_ready_i = 0 for 5 cycles in RESP -> rsp_* stable for all 5 cycles, no acks; ready = 1 -> IDLE next cycle.
REQ-040 Flush: flush_i = 1 in CHECK -> rsp_valid_o stays 0 and a pending dm_req_i is acked 1 cycle later.
REQ-041 Async reset: rst_ni low mid-RESP -> rsp_valid_o = 0 immediately without a clock edge; after release, the first tie goes to fetch.
REQ-042 Data store passthrough: dm_we_i = 1, dm_lock_i = 1, dm_misaligned_i = 1; checker misaligned = 1 -> chk_we_o = chk_lock_o = chk_misaligned_o = 1, chk_instruction_o = 0, rsp_misaligned_o = 1, rsp_port_o = 1.
